// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - bin, LSB first, with valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] d_sr_r;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic             d_s;
    logic             bout_s;

    full_subtractor u_fs (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bout_s)
    );

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_s;
    // Overflow judged on the operand MSBs and the result MSB of the final step.
    assign ovf_s = (a_sr_r[0] ^ b_sr_r[0]) & (a_sr_r[0] ^ d_s);
`endif

    // Next-state and step control.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_s    = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/result shift registers, borrow and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr_r <= '0;
            b_sr_r <= '0;
            d_sr_r <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
        end else if (accept_s) begin
            a_sr_r <= A;
            b_sr_r <= B;
            br_r   <= bin;
            cnt_r  <= '0;
        end else if (step_s) begin
            a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
            b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
            d_sr_r <= {d_s, d_sr_r[WIDTH-1:1]};
            br_r   <= bout_s;
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            a_sr_r <= a_sr_r;
            b_sr_r <= b_sr_r;
            d_sr_r <= d_sr_r;
            br_r   <= br_r;
            cnt_r  <= cnt_r;
        end
    end

    // Registered handshake flags; result captured on the final bit step and held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
            bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_nxt_s == IDLE);
            out_valid <= (state_nxt_s == DONE);
            if (last_s) begin
                D    <= {d_s, d_sr_r[WIDTH-1:1]};
                bout <= bout_s;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= ovf_s;
`endif
            end else begin
                D    <= D;
                bout <= bout;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= ovf;
`endif
            end
        end
    end

endmodule
